// File: rtl/strobe_counter_bank.sv
// rtl/strobe_counter_bank.sv - multi-channel strobe event counter with delay alignment and sticky overflow
// Optional atomic snapshot of counters and timestamp: define STROBE_COUNTER_BANK_SNAPSHOT_EN.
module strobe_counter_bank #(
   parameter int CHANNELS    = 2,
   parameter int WIDTH       = 4,
   parameter int DELAY       = 1,
   parameter int EDGE_MODE   = 0,
   parameter int SATURATE    = 0,
   parameter int CYCLE_WIDTH = 8
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [CHANNELS-1:0]       strobe_in,
   input  logic                      clear,
   input  logic                      capture,
   output logic [CHANNELS*WIDTH-1:0] counts,
   output logic [CHANNELS-1:0]       overflow,
   output logic [CYCLE_WIDTH-1:0]    cycle_count,
   output logic [CHANNELS*WIDTH-1:0] snap_counts,
   output logic [CYCLE_WIDTH-1:0]    snap_cycle,
   output logic                      snap_valid
);

   logic [CHANNELS-1:0] d;
   logic [CHANNELS-1:0] inc;

   generate
      if (DELAY == 0) begin : g_no_delay
         assign d = strobe_in;
      end else begin : g_delay
         logic [CHANNELS-1:0] line [DELAY];
         always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
               for (int i = 0; i < DELAY; i++) line[i] <= '0;
            end else begin
               line[0] <= strobe_in;
               for (int i = 1; i < DELAY; i++) line[i] <= line[i-1];
            end
         end
         assign d = line[DELAY-1];
      end

      // prev tracks the delayed strobe, so the edge is seen after alignment
      if (EDGE_MODE != 0) begin : g_edge
         logic [CHANNELS-1:0] prev;
         always_ff @(posedge clk or posedge reset) begin
            if (reset) prev <= '0;
            else       prev <= d;
         end
         assign inc = d & ~prev;
      end else begin : g_level
         assign inc = d;
      end

      for (genvar k = 0; k < CHANNELS; k++) begin : g_chan
         logic [WIDTH-1:0] cnt;
         logic             ovf;
         always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
               cnt <= '0;
               ovf <= 1'b0;
            end else if (clear) begin
               cnt <= '0;
               ovf <= 1'b0;
            end else if (inc[k]) begin
               if (&cnt) begin
                  ovf <= 1'b1;
                  if (SATURATE == 0) cnt <= '0;
               end else begin
                  cnt <= cnt + WIDTH'(1);
               end
            end
         end
         assign counts[k*WIDTH +: WIDTH] = cnt;
         assign overflow[k]              = ovf;
      end
   endgenerate

   always_ff @(posedge clk or posedge reset) begin
      if (reset) cycle_count <= '0;
      else       cycle_count <= cycle_count + CYCLE_WIDTH'(1);
   end

`ifdef STROBE_COUNTER_BANK_SNAPSHOT_EN
   // Snapshot samples pre-edge values, so a concurrent clear reads-then-clears
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         snap_counts <= '0;
         snap_cycle  <= '0;
         snap_valid  <= 1'b0;
      end else begin
         snap_valid <= capture;
         if (capture) begin
            snap_counts <= counts;
            snap_cycle  <= cycle_count;
         end
      end
   end
`else
   logic unused_capture;
   assign unused_capture = capture;
   assign snap_counts    = '0;
   assign snap_cycle     = '0;
   assign snap_valid     = 1'b0;
`endif

endmodule

// File: doc/strobe_counter_bank.md
# strobe_counter_bank

Multi-channel strobe event counter: the parametrised successor to the two-counter strobe block. It counts strobes on CHANNELS independent inputs, each through a DELAY-cycle alignment pipeline. It supports level or rising-edge counting, wrap or saturate arithmetic, sticky overflow and synchronous clear. An optional snapshot path captures all counters plus a free-running cycle timestamp atomically. It sits beside the PPU/CPU glue as a debug and performance counter for frame, line and bus strobes.

## Interface
- CHANNELS, 2: number of independent strobe channels (1..16).
- WIDTH, 4: counter width per channel in bits (2..32).
- DELAY, 1: input pipeline depth in cycles (0..8). 0 counts strobe_in directly; 1 counts a one-cycle-registered copy.
- EDGE_MODE, 0: 0 counts every cycle the delayed strobe is high; 1 counts only rising edges of it.
- SATURATE, 0: 0 wraps at all-ones; 1 holds at all-ones.
- CYCLE_WIDTH, 8: width of the free-running cycle counter.
- clk  in  1  system clock; all logic on posedge.
- reset  in  1  asynchronous, active-high; clears every register.
- strobe_in  in  CHANNELS  per-channel strobe, bit k is channel k.
- clear  in  1  synchronous clear of all counters and overflow flags.
- capture  in  1  snapshot request (effective only with the snapshot macro).
- counts  out  CHANNELS*WIDTH  live counters; channel k is bits [k*WIDTH +: WIDTH].
- overflow  out  CHANNELS  sticky per-channel overflow flag.
- cycle_count  out  CYCLE_WIDTH  free-running cycle counter.
- snap_counts  out  CHANNELS*WIDTH  captured counters.
- snap_cycle  out  CYCLE_WIDTH  captured cycle_count.
- snap_valid  out  1  one-cycle pulse when snapshot registers update.

## Operation
- Reset: all outputs, delay lines and edge-history registers are 0.
- Delay line per channel: DELAY registers. The delayed strobe d[k] is strobe_in[k] from DELAY cycles earlier; with DELAY=0, d[k]=strobe_in[k].
- Increment condition inc[k]:
  - Level mode: d[k].
  - Edge mode: d[k] & ~prev[k], where prev[k] is d[k] registered, reset 0. A strobe held high from the end of reset therefore counts once.
- Arithmetic:
  - Wrap mode: all-ones + 1 gives 0 and sets overflow[k].
  - Saturate mode: an increment at all-ones leaves the count unchanged and sets overflow[k].
  - overflow[k] stays set until clear or reset.
- Clear has priority over increment. Counters and overflow go to 0 and an increment in the same cycle is dropped.
- Clear does not flush delay lines or prev. Strobes in flight are counted after the clear.
- cycle_count increments every cycle, wraps, and is cleared only by reset.
- All channels are fully independent; simultaneous increments on all channels are supported.

## Timing
- Level mode: strobe_in[k] high in the cycle before posedge t makes counts[k] show +1 after posedge t+DELAY.
- Edge mode: same latency, measured from the rising edge.
- overflow[k] updates on the same edge as the wrapping or saturating increment.
- Capture sampled at posedge t:
  - snap_counts and snap_cycle take the values visible during the cycle before t, i.e. the pre-edge values, excluding any increment at t.
  - snap_valid is high for the cycle following t.
- Capture and clear in the same cycle: the snapshot gets pre-clear values and the counters go to 0 (clear-on-read).
- Back-to-back captures are legal; each one updates the snapshot and holds snap_valid high.
- Reset asserted mid-operation: immediate asynchronous clear of everything, including snapshot registers and pending delay-line strobes.

## Configuration
- STROBE_COUNTER_BANK_SNAPSHOT_EN:
  - Defined: the snapshot registers and capture logic are built as described.
  - Undefined: capture is ignored, and snap_counts, snap_cycle and snap_valid are tied to constant 0 with no registers inferred.
  - All other behaviour is identical either way.

## Test plan
- CHANNELS=2, DELAY=1, level mode. Strobe ch0 high for 3 cycles starting 2 cycles after reset release -> counts[0] reads 1, 2, 3 after the 2nd, 3rd and 4th edges of the pulse; ch1 stays 0.
- DELAY=0 vs DELAY=3, same single-cycle strobe -> the DELAY=3 count changes exactly 3 edges after the DELAY=0 count.
- Edge mode, WIDTH=4. Strobe held high 10 cycles, low 1 cycle, high 1 cycle -> count=2.
- WIDTH=4, wrap. 17 single-cycle strobes -> count=1, overflow=1. Same stimulus with SATURATE=1 -> count=15, overflow=1.
- Count at 5, clear and strobe asserted in the same cycle (DELAY=0) -> count=0. A strobe in the DELAY=2 pipeline at the clear -> count=1 two edges later.
- Snapshot macro on. Counts 7/3, cycle_count=40, capture together with clear -> one cycle later snap_counts=7/3, snap_cycle=40, snap_valid=1, live counts=0/0. Macro off, same stimulus -> snap outputs stay 0.
